axi_write_master_vdma: RTL and testbench



---
 rtl/axi_write_master_vdma.sv | 182 ++++++++++++++++++
 tb/tb_axi_write_master_vdma.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_master_vdma.sv
// AXI4 write master on the VDMA DDR path. It issues one burst at a time and uses an FWFT
// beat buffer to absorb the upstream beat stream, which cannot be stalled, before W.
module axi_write_master_vdma #(
   parameter int unsigned g_AXI_DW = 64,
   parameter int unsigned g_AXI_AW = 38,
   parameter int unsigned g_BUF_AW = 8
) (
   input  logic                  ddr_clk_i,
   input  logic                  ddr_clk_rst_i,
   input  logic                  write_req_i,
   input  logic [7:0]            write_length_i,
   input  logic [g_AXI_AW-1:0]   write_start_addr_i,
   input  logic                  data_valid_i,
   input  logic [g_AXI_DW-1:0]   data_i,
   output logic                  write_ackn_o,
   output logic                  write_done_o,
   output logic [g_AXI_AW-1:0]   awaddr_o,
   output logic [7:0]            awlen_o,
   output logic [2:0]            awsize_o,
   output logic [1:0]            awburst_o,
   output logic [3:0]            awid_o,
   output logic                  awvalid_o,
   input  logic                  awready_i,
   output logic [g_AXI_DW-1:0]   wdata_o,
   output logic [g_AXI_DW/8-1:0] wstrb_o,
   output logic                  wlast_o,
   output logic                  wvalid_o,
   input  logic                  wready_i,
   input  logic [3:0]            bid_i,
   input  logic [1:0]            bresp_i,
   input  logic                  bvalid_i,
   output logic                  bready_o,
   output logic                  busy_o,
   output logic                  resp_err_o,
   output logic                  ovf_err_o
);

   localparam int unsigned Depth = 2 ** g_BUF_AW;
   localparam logic [g_BUF_AW:0] DepthC = (g_BUF_AW + 1)'(Depth);
   localparam logic [2:0] AwSize = 3'($clog2(g_AXI_DW / 8));

   typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

   state_e              state_q, state_d;
   logic [g_AXI_AW-1:0] awaddr_q, awaddr_d;
   logic [7:0]          awlen_q, awlen_d;
   logic [7:0]          beat_q, beat_d;
   logic                awvalid_q, awvalid_d;
   logic                ackn_q, ackn_d;
   logic                done_q, done_d;
   logic                resp_err_q, resp_err_d;
   logic                ovf_err_q, ovf_err_d;

   logic [g_AXI_DW-1:0] mem_q [Depth];
   logic [g_BUF_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [g_BUF_AW:0]   cnt_q, cnt_d;
   logic                empty, full, push, pop, wvalid, wlast;
   logic                unused_in;

   // bid_i carries no information for a single-ID master
   assign unused_in = ^{bid_i, bresp_i[0]};

   always_comb begin
      empty  = (cnt_q == '0);
      full   = (cnt_q == DepthC);
      wvalid = (state_q == StData) && !empty;
      wlast  = wvalid && (beat_q == awlen_q);
      pop    = wvalid && wready_i;
      // A pop in the same cycle frees the slot, so a write while full still lands
      push   = data_valid_i && (!full || pop);

      wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      ovf_err_d = ovf_err_q | (data_valid_i && full && !pop);
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      awaddr_d   = awaddr_q;
      awlen_d    = awlen_q;
      beat_d     = beat_q;
      awvalid_d  = awvalid_q;
      ackn_d     = 1'b0;
      done_d     = 1'b0;
      resp_err_d = resp_err_q;
      unique case (state_q)
         StIdle: begin
            if (write_req_i) begin
               awaddr_d  = write_start_addr_i;
               awlen_d   = write_length_i;
               awvalid_d = 1'b1;
               state_d   = StAddr;
            end
         end
         StAddr: begin
            if (awready_i) begin
               awvalid_d = 1'b0;
               ackn_d    = 1'b1;
               beat_d    = '0;
               state_d   = StData;
            end
         end
         StData: begin
            if (pop) begin
               if (wlast) begin
                  beat_d  = '0;
                  state_d = StResp;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         StResp: begin
            if (bvalid_i) begin
               done_d     = 1'b1;
               resp_err_d = resp_err_q | bresp_i[1];
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge ddr_clk_i) begin
      if (ddr_clk_rst_i) begin
         state_q    <= StIdle;
         awaddr_q   <= '0;
         awlen_q    <= '0;
         beat_q     <= '0;
         awvalid_q  <= 1'b0;
         ackn_q     <= 1'b0;
         done_q     <= 1'b0;
         resp_err_q <= 1'b0;
         ovf_err_q  <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         awaddr_q   <= awaddr_d;
         awlen_q    <= awlen_d;
         beat_q     <= beat_d;
         awvalid_q  <= awvalid_d;
         ackn_q     <= ackn_d;
         done_q     <= done_d;
         resp_err_q <= resp_err_d;
         ovf_err_q  <= ovf_err_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
      end
   end

   always_ff @(posedge ddr_clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   assign write_ackn_o = ackn_q;
   assign write_done_o = done_q;
   assign awaddr_o     = awaddr_q;
   assign awlen_o      = awlen_q;
   assign awsize_o     = AwSize;
   assign awburst_o    = 2'b01;
   assign awid_o       = 4'd0;
   assign awvalid_o    = awvalid_q;
   assign wdata_o      = wvalid ? mem_q[rd_ptr_q] : '0;
   assign wstrb_o      = '1;
   assign wlast_o      = wlast;
   assign wvalid_o     = wvalid;
   assign bready_o     = (state_q == StResp);
   assign busy_o       = (state_q != StIdle);
   assign resp_err_o   = resp_err_q;
   assign ovf_err_o    = ovf_err_q;

endmodule

// File: tb/tb_axi_write_master_vdma.sv
// Directed bench for axi_write_master_vdma: table of bursts plus hand-written reset-mid-burst
// and buffer-overflow sequences.
module tb_axi_write_master_vdma;

   logic        clk = 1'b0;
   logic        rst;
   logic        write_req_i;
   logic [7:0]  write_length_i;
   logic [37:0] write_start_addr_i;
   logic        data_valid_i;
   logic [63:0] data_i;
   logic        write_ackn_o, write_done_o;
   logic [37:0] awaddr_o;
   logic [7:0]  awlen_o;
   logic [2:0]  awsize_o;
   logic [1:0]  awburst_o;
   logic [3:0]  awid_o;
   logic        awvalid_o, awready_i;
   logic [63:0] wdata_o;
   logic [7:0]  wstrb_o;
   logic        wlast_o, wvalid_o, wready_i;
   logic [3:0]  bid_i;
   logic [1:0]  bresp_i;
   logic        bvalid_i, bready_o;
   logic        busy_o, resp_err_o, ovf_err_o;

   always #5 clk = ~clk;

   axi_write_master_vdma #(
      .g_AXI_DW (64),
      .g_AXI_AW (38),
      .g_BUF_AW (8)
   ) dut (
      .ddr_clk_i          (clk),
      .ddr_clk_rst_i      (rst),
      .write_req_i        (write_req_i),
      .write_length_i     (write_length_i),
      .write_start_addr_i (write_start_addr_i),
      .data_valid_i       (data_valid_i),
      .data_i             (data_i),
      .write_ackn_o       (write_ackn_o),
      .write_done_o       (write_done_o),
      .awaddr_o           (awaddr_o),
      .awlen_o            (awlen_o),
      .awsize_o           (awsize_o),
      .awburst_o          (awburst_o),
      .awid_o             (awid_o),
      .awvalid_o          (awvalid_o),
      .awready_i          (awready_i),
      .wdata_o            (wdata_o),
      .wstrb_o            (wstrb_o),
      .wlast_o            (wlast_o),
      .wvalid_o           (wvalid_o),
      .wready_i           (wready_i),
      .bid_i              (bid_i),
      .bresp_i            (bresp_i),
      .bvalid_i           (bvalid_i),
      .bready_o           (bready_o),
      .busy_o             (busy_o),
      .resp_err_o         (resp_err_o),
      .ovf_err_o          (ovf_err_o)
   );

   typedef struct {
      logic [7:0]  len;
      logic [37:0] addr;
      int          aw_delay;
      int          w_mode;   // 0: wready held high, 1: wready toggles every cycle
      int          b_delay;
      logic [1:0]  bresp;
      logic        exp_err;
   } vec_t;

   vec_t vecs [7];
   int   n_vec = 0;
   int   n_bad = 0;
   int   tag   = 0;

   function automatic logic [63:0] beat(input int t, input int i);
      return {t, i};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_idle(input string p);
      chk({p, "_awvalid"}, 64'(awvalid_o), 64'(0));
      chk({p, "_awaddr"}, 64'(awaddr_o), 64'(0));
      chk({p, "_awlen"}, 64'(awlen_o), 64'(0));
      chk({p, "_wvalid"}, 64'(wvalid_o), 64'(0));
      chk({p, "_wlast"}, 64'(wlast_o), 64'(0));
      chk({p, "_wdata"}, wdata_o, 64'(0));
      chk({p, "_ackn"}, 64'(write_ackn_o), 64'(0));
      chk({p, "_done"}, 64'(write_done_o), 64'(0));
      chk({p, "_bready"}, 64'(bready_o), 64'(0));
      chk({p, "_busy"}, 64'(busy_o), 64'(0));
      chk({p, "_resp_err"}, 64'(resp_err_o), 64'(0));
      chk({p, "_ovf_err"}, 64'(ovf_err_o), 64'(0));
      chk({p, "_awsize"}, 64'(awsize_o), 64'(3));
      chk({p, "_awburst"}, 64'(awburst_o), 64'(1));
      chk({p, "_wstrb"}, 64'(wstrb_o), 64'(8'hff));
      chk({p, "_awid"}, 64'(awid_o), 64'(0));
   endtask

   // Runs one full burst starting at a negedge; returns at the negedge where done is seen.
   task automatic run_burst(input vec_t v);
      int acks = 0, dones = 0, beats = 0, lasts = 0, aw_hs = 0;
      int pushed = 0, aw_wait = 0, b_wait = 0, cyc = 0;
      bit feeding = 0, w_done = 0, aw_done = 0, finished = 0;
      tag++;
      write_req_i        = 1'b1;
      write_length_i     = v.len;
      write_start_addr_i = v.addr;
      while (!finished && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (write_ackn_o) begin
            acks++;
            chk("ackn_after_aw_hs", 64'(aw_done), 64'(1));
            write_req_i = 1'b0;
            feeding     = 1'b1;
         end
         if (write_done_o) begin
            dones++;
            finished = 1'b1;
         end
         if (awvalid_o) begin
            chk("awaddr", 64'(awaddr_o), 64'(v.addr));
            chk("awlen", 64'(awlen_o), 64'(v.len));
            awready_i = (aw_wait >= v.aw_delay);
            aw_wait++;
            if (awready_i) begin
               aw_done = 1'b1;
               aw_hs++;
            end
         end else begin
            awready_i = 1'b0;
         end
         if (feeding && pushed <= int'(v.len)) begin
            data_valid_i = 1'b1;
            data_i       = beat(tag, pushed);
            pushed++;
         end else begin
            data_valid_i = 1'b0;
         end
         wready_i = (v.w_mode == 0) ? 1'b1 : cyc[0];
         if (wvalid_o) begin
            chk("wdata", wdata_o, beat(tag, beats));
            chk("wlast", 64'(wlast_o), 64'(beats == int'(v.len)));
            if (wready_i) begin
               if (wlast_o) begin
                  lasts++;
                  w_done = 1'b1;
               end
               beats++;
            end
         end else begin
            chk("wlast_without_wvalid", 64'(wlast_o), 64'(0));
         end
         if (bready_o && w_done) begin
            bvalid_i = (b_wait >= v.b_delay);
            bresp_i  = v.bresp;
            b_wait++;
         end else begin
            bvalid_i = 1'b0;
            bresp_i  = 2'b00;
         end
      end
      chk("burst_finished", 64'(finished), 64'(1));
      chk("ackn_pulses", 64'(acks), 64'(1));
      chk("done_pulses", 64'(dones), 64'(1));
      chk("aw_handshakes", 64'(aw_hs), 64'(1));
      chk("w_beats", 64'(beats), 64'(int'(v.len) + 1));
      chk("wlast_count", 64'(lasts), 64'(1));
      chk("resp_err", 64'(resp_err_o), 64'(v.exp_err));
      chk("ovf_err", 64'(ovf_err_o), 64'(0));
      chk("busy_after_done", 64'(busy_o), 64'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int idx;
      vec_t fresh;

      vecs[0] = '{len: 8'd15,  addr: 38'h0_1000_0000, aw_delay: 0, w_mode: 0, b_delay: 3,
                  bresp: 2'b00, exp_err: 1'b0};
      vecs[1] = '{len: 8'd15,  addr: 38'h0_2000_0040, aw_delay: 5, w_mode: 1, b_delay: 1,
                  bresp: 2'b00, exp_err: 1'b0};
      vecs[2] = '{len: 8'd0,   addr: 38'h3_0000_0000, aw_delay: 0, w_mode: 0, b_delay: 0,
                  bresp: 2'b00, exp_err: 1'b0};
      vecs[3] = '{len: 8'd255, addr: 38'h0_4000_0000, aw_delay: 0, w_mode: 0, b_delay: 0,
                  bresp: 2'b00, exp_err: 1'b0};
      vecs[4] = '{len: 8'd7,   addr: 38'h0_5000_0000, aw_delay: 2, w_mode: 1, b_delay: 2,
                  bresp: 2'b10, exp_err: 1'b1};
      vecs[5] = '{len: 8'd3,   addr: 38'h0_6000_0000, aw_delay: 0, w_mode: 0, b_delay: 0,
                  bresp: 2'b00, exp_err: 1'b1};
      vecs[6] = '{len: 8'd1,   addr: 38'h0_6000_1000, aw_delay: 1, w_mode: 1, b_delay: 4,
                  bresp: 2'b01, exp_err: 1'b1};
      fresh   = '{len: 8'd15,  addr: 38'h0_7000_2000, aw_delay: 1, w_mode: 0, b_delay: 1,
                  bresp: 2'b00, exp_err: 1'b0};

      rst                = 1'b1;
      write_req_i        = 1'b0;
      write_length_i     = '0;
      write_start_addr_i = '0;
      data_valid_i       = 1'b0;
      data_i             = '0;
      awready_i          = 1'b0;
      wready_i           = 1'b0;
      bid_i              = 4'ha;
      bresp_i            = 2'b00;
      bvalid_i           = 1'b0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         run_burst(vecs[i]);
      end

      // Reset after 5 of 16 beats have gone out on W
      tag++;
      write_req_i        = 1'b1;
      write_length_i     = 8'd15;
      write_start_addr_i = 38'h0_7000_0000;
      wready_i           = 1'b0;
      cnt = 0;
      while (!awvalid_o && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("rst_seq_awvalid", 64'(awvalid_o), 64'(1));
      awready_i = 1'b1;
      @(negedge clk);
      awready_i = 1'b0;
      chk("rst_seq_ackn", 64'(write_ackn_o), 64'(1));
      write_req_i = 1'b0;
      for (int i = 0; i < 16; i++) begin
         data_valid_i = 1'b1;
         data_i       = beat(tag, i);
         @(negedge clk);
      end
      data_valid_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wready_i = 1'b1;
         chk("rst_seq_wdata", wdata_o, beat(tag, i));
         @(negedge clk);
      end
      wready_i = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      check_idle("mid_rst");
      rst = 1'b0;
      run_burst(fresh);

      // Overflow: 257 beats into a 256-deep buffer with W stalled
      tag++;
      write_req_i        = 1'b1;
      write_length_i     = 8'd255;
      write_start_addr_i = 38'h0_8000_0000;
      wready_i           = 1'b0;
      cnt = 0;
      while (!awvalid_o && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("ovf_seq_awvalid", 64'(awvalid_o), 64'(1));
      awready_i = 1'b1;
      @(negedge clk);
      awready_i = 1'b0;
      chk("ovf_seq_ackn", 64'(write_ackn_o), 64'(1));
      write_req_i = 1'b0;
      for (int i = 0; i < 257; i++) begin
         if (i == 256) chk("ovf_before_257th", 64'(ovf_err_o), 64'(0));
         data_valid_i = 1'b1;
         data_i       = beat(tag, i);
         @(negedge clk);
      end
      data_valid_i = 1'b0;
      chk("ovf_after_257th", 64'(ovf_err_o), 64'(1));
      idx      = 0;
      cnt      = 0;
      wready_i = 1'b1;
      while (idx < 256 && cnt < 400) begin
         if (wvalid_o) begin
            chk("ovf_drain_wdata", wdata_o, beat(tag, idx));
            chk("ovf_drain_wlast", 64'(wlast_o), 64'(idx == 255));
            idx++;
         end
         @(negedge clk);
         cnt++;
      end
      chk("ovf_drain_beats", 64'(idx), 64'(256));
      chk("ovf_no_extra_beat", 64'(wvalid_o), 64'(0));
      cnt = 0;
      while (!bready_o && cnt < 10) begin
         @(negedge clk);
         cnt++;
      end
      chk("ovf_bready", 64'(bready_o), 64'(1));
      bvalid_i = 1'b1;
      bresp_i  = 2'b00;
      @(negedge clk);
      bvalid_i = 1'b0;
      chk("ovf_done", 64'(write_done_o), 64'(1));
      chk("ovf_sticky", 64'(ovf_err_o), 64'(1));
      chk("ovf_resp_err", 64'(resp_err_o), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
